// File: rtl/keypad_pkg.sv
// Shared keypad-path definitions: entry FSM encoding, blank nibble code and key-vector width.
package keypad_pkg;

   localparam int         KEY_WIDTH          = 10;
   localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } state_t;

endpackage

// File: rtl/key_digit_shifter_if.sv
// Bus between the keypad detector/host side and the digit shifter; state is carried for debug visibility.
interface key_digit_shifter_if
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) ();

   logic [KEY_WIDTH-1:0]    keys;
   logic                    shift_valid;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [3:0]              digit_count;
   logic                    full;
   logic                    accepted;
   state_t                  state;

   modport master (
      output keys, shift_valid, clear,
      input  digits, digit_count, full, accepted, state
   );

   modport slave (
      input  keys, shift_valid, clear,
      output digits, digit_count, full, accepted, state
   );

endinterface

// File: rtl/key_onehot_to_bcd.sv
// Lowest-set-bit priority encoder from the 10-bit key vector to a BCD digit plus hit flag.
module key_onehot_to_bcd
   import keypad_pkg::*;
(
   input  logic [KEY_WIDTH-1:0] onehot,
   output logic [3:0]           bcd,
   output logic                 hit
);

   // Scanning downward lets the lowest set index overwrite any higher one.
   always_comb begin
      bcd = 4'd0;
      hit = 1'b0;
      for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
         if (onehot[i]) begin
            bcd = 4'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_digit_shifter.sv
// Encodes newly pressed keys to BCD and shifts them into an N-digit entry register.
// Optional macro KEY_DIGIT_SHIFTER_LOCK_FULL_EN: once FULL, further strobes are ignored until clear/rst.
module key_digit_shifter
   import keypad_pkg::*;
#(
   parameter int         NUM_DIGITS = 4,
   parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
   input logic                 clk,
   input logic                 rst,
   key_digit_shifter_if.slave  bus
);

   localparam logic [3:0] COUNT_MAX = 4'(NUM_DIGITS);

   logic [KEY_WIDTH-1:0]    keys_q;
   logic [KEY_WIDTH-1:0]    new_mask;
   logic [3:0]              new_bcd, any_bcd, sel_bcd;
   logic                    new_hit, any_hit, key_changed, shift_req;
   state_t                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [3:0]              count_q, count_d;
   logic                    accepted_q, accepted_d;

   assign new_mask    = bus.keys & ~keys_q;
   assign key_changed = (bus.keys != keys_q);

   key_onehot_to_bcd u_new_enc (.onehot(new_mask), .bcd(new_bcd), .hit(new_hit));
   key_onehot_to_bcd u_any_enc (.onehot(bus.keys), .bcd(any_bcd), .hit(any_hit));

   assign sel_bcd = new_hit ? new_bcd : any_bcd;

   // Fallback to the held keys only when the vector actually changed (a release
   // alongside the strobe); an unchanged held key must not re-enter.
`ifdef KEY_DIGIT_SHIFTER_LOCK_FULL_EN
   assign shift_req = bus.shift_valid && (new_hit || (key_changed && any_hit))
                      && (state_q != FULL);
`else
   assign shift_req = bus.shift_valid && (new_hit || (key_changed && any_hit));
`endif

   always_comb begin
      state_d    = state_q;
      digits_d   = digits_q;
      count_d    = count_q;
      accepted_d = 1'b0;
      if (bus.clear) begin
         state_d  = EMPTY;
         digits_d = {NUM_DIGITS{BLANK_CODE}};
         count_d  = 4'd0;
      end else if (shift_req) begin
         digits_d[3:0] = sel_bcd;
         for (int i = 1; i < NUM_DIGITS; i++) begin
            digits_d[4*i +: 4] = digits_q[4*(i-1) +: 4];
         end
         if (count_q < COUNT_MAX) begin
            count_d = count_q + 4'd1;
         end
         accepted_d = 1'b1;
         case (state_q)
            EMPTY:   state_d = (NUM_DIGITS == 1) ? FULL : FILLING;
            FILLING: state_d = (count_q + 4'd1 == COUNT_MAX) ? FULL : FILLING;
            FULL:    state_d = FULL;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keys_q     <= '0;
         state_q    <= EMPTY;
         digits_q   <= {NUM_DIGITS{BLANK_CODE}};
         count_q    <= 4'd0;
         accepted_q <= 1'b0;
      end else begin
         keys_q     <= bus.keys;
         state_q    <= state_d;
         digits_q   <= digits_d;
         count_q    <= count_d;
         accepted_q <= accepted_d;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.digit_count = count_q;
   assign bus.full        = (state_q == FULL);
   assign bus.accepted    = accepted_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_key_digit_shifter.sv
// Directed bench for key_digit_shifter with NUM_DIGITS = 4 and hand-computed expectations.
module tb_key_digit_shifter;
   import keypad_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   key_digit_shifter_if #(.NUM_DIGITS(4)) bif ();

   key_digit_shifter #(.NUM_DIGITS(4), .BLANK_CODE(4'hF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bif.keys = '0; bif.shift_valid = 1'b0; bif.clear = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   // Press with a strobe; on return the stored digit is visible with accepted high.
   task automatic press(input logic [9:0] k);
      bif.keys = k; bif.shift_valid = 1'b1;
      step();
      bif.shift_valid = 1'b0;
   endtask

   task automatic release_all();
      bif.keys = '0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bif.digits !== 16'hFFFF) begin bad++; $display("FAIL reset_digits got=%h exp=FFFF", bif.digits); end
      total++; if (bif.digit_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bif.digit_count); end
      total++; if (bif.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bif.full); end
      total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL reset_acc got=%b exp=0", bif.accepted); end
      total++; if (bif.state !== EMPTY) begin bad++; $display("FAIL reset_state got=%0d exp=0", bif.state); end
   endtask

   task automatic test_single();
      do_reset();
      press(10'h008);
      total++; if (bif.digits !== 16'hFFF3) begin bad++; $display("FAIL single_digits got=%h exp=FFF3", bif.digits); end
      total++; if (bif.digit_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bif.digit_count); end
      total++; if (bif.accepted !== 1'b1) begin bad++; $display("FAIL single_acc got=%b exp=1", bif.accepted); end
      total++; if (bif.state !== FILLING) begin bad++; $display("FAIL single_state got=%0d exp=1", bif.state); end
      release_all();
      total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL single_acc_pulse got=%b exp=0", bif.accepted); end
   endtask

   task automatic test_fill();
      do_reset();
      press(10'h002); release_all();
      press(10'h004); release_all();
      press(10'h008); release_all();
      press(10'h010);
      total++; if (bif.digits !== 16'h1234) begin bad++; $display("FAIL fill_digits got=%h exp=1234", bif.digits); end
      total++; if (bif.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bif.full); end
      total++; if (bif.digit_count !== 4'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bif.digit_count); end
      total++; if (bif.state !== FULL) begin bad++; $display("FAIL fill_state got=%0d exp=2", bif.state); end
      release_all();
      press(10'h020);
`ifdef KEY_DIGIT_SHIFTER_LOCK_FULL_EN
      total++; if (bif.digits !== 16'h1234) begin bad++; $display("FAIL full_shift_digits got=%h exp=1234", bif.digits); end
      total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL full_shift_acc got=%b exp=0", bif.accepted); end
`else
      total++; if (bif.digits !== 16'h2345) begin bad++; $display("FAIL full_shift_digits got=%h exp=2345", bif.digits); end
      total++; if (bif.accepted !== 1'b1) begin bad++; $display("FAIL full_shift_acc got=%b exp=1", bif.accepted); end
`endif
      total++; if (bif.digit_count !== 4'd4) begin bad++; $display("FAIL full_shift_count got=%0d exp=4", bif.digit_count); end
      total++; if (bif.full !== 1'b1) begin bad++; $display("FAIL full_shift_full got=%b exp=1", bif.full); end
      release_all();
   endtask

   task automatic test_hold();
      do_reset();
      press(10'h080);
      total++; if (bif.digits !== 16'hFFF7) begin bad++; $display("FAIL hold_first got=%h exp=FFF7", bif.digits); end
      total++; if (bif.accepted !== 1'b1) begin bad++; $display("FAIL hold_first_acc got=%b exp=1", bif.accepted); end
      for (int i = 0; i < 3; i++) begin
         bif.shift_valid = 1'b1;
         step();
         total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL hold_acc[%0d] got=%b exp=0", i, bif.accepted); end
         total++; if (bif.digits !== 16'hFFF7) begin bad++; $display("FAIL hold_digits[%0d] got=%h exp=FFF7", i, bif.digits); end
      end
      bif.shift_valid = 1'b0;
      total++; if (bif.digit_count !== 4'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", bif.digit_count); end
      release_all();
   endtask

   task automatic test_clear();
      do_reset();
      press(10'h002); release_all();
      bif.keys = 10'h200; bif.shift_valid = 1'b1; bif.clear = 1'b1;
      step();
      bif.shift_valid = 1'b0; bif.clear = 1'b0;
      total++; if (bif.digits !== 16'hFFFF) begin bad++; $display("FAIL clear_digits got=%h exp=FFFF", bif.digits); end
      total++; if (bif.digit_count !== 4'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", bif.digit_count); end
      total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL clear_acc got=%b exp=0", bif.accepted); end
      total++; if (bif.state !== EMPTY) begin bad++; $display("FAIL clear_state got=%0d exp=0", bif.state); end
      release_all();
   endtask

   task automatic test_fallback();
      do_reset();
      press(10'h044);
      total++; if (bif.digits !== 16'hFFF2) begin bad++; $display("FAIL dual_digits got=%h exp=FFF2", bif.digits); end
      bif.keys = 10'h040; bif.shift_valid = 1'b1;
      step();
      bif.shift_valid = 1'b0;
      total++; if (bif.digits !== 16'hFF26) begin bad++; $display("FAIL fallback_digits got=%h exp=FF26", bif.digits); end
      total++; if (bif.accepted !== 1'b1) begin bad++; $display("FAIL fallback_acc got=%b exp=1", bif.accepted); end
      total++; if (bif.digit_count !== 4'd2) begin bad++; $display("FAIL fallback_count got=%0d exp=2", bif.digit_count); end
      release_all();
   endtask

   task automatic test_reset_mid();
      // Entry left in FILLING with count 2 by the previous scenario.
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (bif.digits !== 16'hFFFF) begin bad++; $display("FAIL midrst_digits got=%h exp=FFFF", bif.digits); end
      total++; if (bif.digit_count !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bif.digit_count); end
      total++; if (bif.state !== EMPTY) begin bad++; $display("FAIL midrst_state got=%0d exp=0", bif.state); end
      bif.keys = '0; bif.shift_valid = 1'b1;
      step();
      bif.shift_valid = 1'b0;
      total++; if (bif.accepted !== 1'b0) begin bad++; $display("FAIL nokey_acc got=%b exp=0", bif.accepted); end
      total++; if (bif.digits !== 16'hFFFF) begin bad++; $display("FAIL nokey_digits got=%h exp=FFFF", bif.digits); end
   endtask

   task automatic test_back_to_back();
      logic [9:0]  k_tab [3];
      logic [15:0] d_tab [3];
      k_tab[0] = 10'h001; k_tab[1] = 10'h002; k_tab[2] = 10'h004;
      d_tab[0] = 16'hFFF0; d_tab[1] = 16'hFF01; d_tab[2] = 16'hF012;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bif.keys = k_tab[i]; bif.shift_valid = 1'b1;
         step();
         total++; if (bif.digits !== d_tab[i]) begin bad++; $display("FAIL b2b_digits[%0d] got=%h exp=%h", i, bif.digits, d_tab[i]); end
         total++; if (bif.accepted !== 1'b1) begin bad++; $display("FAIL b2b_acc[%0d] got=%b exp=1", i, bif.accepted); end
      end
      bif.shift_valid = 1'b0;
      total++; if (bif.digit_count !== 4'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", bif.digit_count); end
      release_all();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bif.keys = '0; bif.shift_valid = 1'b0; bif.clear = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_hold();
      test_clear();
      test_fallback();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_digit_shifter.md
Name: key_digit_shifter

Overview:
- Sits directly downstream of the key-press detector in the keypad entry path.
- Consumes the 10-bit decimal key-down vector and its one-cycle shift_valid strobe.
- Encodes the newly pressed key to BCD and shifts it into an N-digit entry register that feeds the 7-segment scan/display stage.
- Tracks the entry count and fill state, and emits a one-cycle accept pulse per digit stored.

Parameters:
- NUM_DIGITS, 4: number of BCD digit slots held; legal range 1..8.
- BLANK_CODE, 4'hF: nibble value for an empty slot, decoded as a blank by the display stage.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- keys  input  10  key-down level vector; bit i high means decimal key i is held.
- shift_valid  input  1  new-press strobe from the upstream detector, same cycle as the keys change.
- clear  input  1  synchronous clear of the entry, one cycle wide or longer.
- digits  output  4*NUM_DIGITS  BCD entry; newest digit in [3:0], oldest in the top nibble.
- digit_count  output  4  number of valid digits, saturating at NUM_DIGITS.
- full  output  1  high when digit_count == NUM_DIGITS.
- accepted  output  1  one-cycle pulse, registered, in the cycle after a digit is stored.

Behaviour:
- Reset (rst high at an edge):
  - digits = all BLANK_CODE; digit_count = 0; full = 0; accepted = 0; keys_q = 0; state = EMPTY.
  - Reset overrides clear and shift_valid.
  - A reset in the middle of an entry discards all digits.
- keys_q register: captures keys every cycle.
- new_mask = keys & ~keys_q.
- Key selection when shift_valid = 1:
  - Selected key = lowest set bit index of new_mask.
  - If new_mask == 0, use the lowest set bit of keys (covers a release and a press in the same cycle).
  - If keys == 0, the strobe is ignored: no shift and no accepted pulse.
- Shift action, registered, visible the cycle after the strobe:
  - digits <= {digits[4*NUM_DIGITS-5:0], bcd}.
  - digit_count increments, saturating at NUM_DIGITS.
  - accepted = 1 for exactly one cycle.
- State machine:
  - EMPTY to FILLING on the first accepted digit; to FULL directly if NUM_DIGITS == 1.
  - FILLING to FULL when the increment reaches NUM_DIGITS.
  - FULL stays FULL on a shift: the oldest digit drops off the top and count stays at NUM_DIGITS.
  - Any state goes to EMPTY on clear.
- clear takes priority over shift_valid in the same cycle:
  - Digits are blanked and count goes to 0.
  - accepted = 0; the key is lost.
- full is decoded from state (FULL); it is not a separate counter compare.
- Consecutive shift_valid cycles each shift one digit; there is no rate limit.
- Held keys: a key that stays down produces no new_mask bit and therefore no re-entry, even if shift_valid is asserted.
- Width: bcd is 4 bits, range 0..9. digit_count is 4 bits, which covers NUM_DIGITS ≤ 8.

Optional Feature:
- Macro: KEY_DIGIT_SHIFTER_LOCK_FULL_EN.
- Defined:
  - In FULL, shift_valid is ignored: digits unchanged, accepted = 0.
  - Only clear or rst leave FULL.
- Undefined (default): FULL behaves as a sliding window, as described in Behaviour.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding: EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2;
  - BLANK_CODE default;
  - the key-vector width constant (10).
- One sub-module, key_onehot_to_bcd: combinational lowest-set-bit priority encoder, 10-bit input, 4-bit bcd plus a hit flag.
  - The top level instantiates it twice: once on new_mask and once on keys for the fallback.

Test Plan:
- Reset, then press key 3 (keys=10'h008 with a shift_valid pulse) -> next cycle digits=16'hFFF3, digit_count=1, accepted=1 for one cycle.
- Press keys 1, 2, 3, 4 with releases between presses -> digits=16'h1234, full=1. Then press 5 -> digits=16'h2345, count stays 4 (macro undefined); with the macro defined, digits stay 16'h1234 and accepted=0.
- Hold key 7 while shift_valid is pulsed for 3 cycles after the initial press -> exactly one digit 7 stored and one accepted pulse.
- Assert clear and shift_valid (key 9) in the same cycle -> digits=16'hFFFF, count=0, accepted=0, state EMPTY.
- Press keys 2 and 6 in the same cycle -> digit 2 stored. Then release 2 while 6 stays held and strobe with new_mask=0 -> fallback stores 6.
- rst high during FILLING with count=2 -> next cycle all outputs at reset values. shift_valid with keys=0 -> no change.
